// File: rtl/pipe_ctrl_pkg.sv
// Opcodes, ALU/immediate/result encodings and control-word types shared by the
// RV32I pipeline control unit and its decoder.
package pipe_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] SRCA_RS1  = 2'b00;
   localparam logic [1:0] SRCA_PC   = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       jump;
      logic       branch;
      logic       jalr;
      logic [1:0] alusrc_a;
      logic       alusrc_b;
      logic [3:0] alucontrol;
      logic [1:0] resultsrc;
      logic [2:0] immsrc;
      logic       illegal;
   } ctrl_t;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       jump;
      logic       branch;
      logic       jalr;
      logic [1:0] alusrc_a;
      logic       alusrc_b;
      logic [3:0] alucontrol;
      logic [1:0] resultsrc;
      logic       illegal;
      logic [2:0] funct3;
   } ex_ctrl_t;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic [1:0] resultsrc;
      logic       illegal;
   } mem_ctrl_t;

   typedef struct packed {
      logic       regwrite;
      logic [1:0] resultsrc;
      logic       illegal;
   } wb_ctrl_t;

   // alt selects the alternate operation (SUB for 000, SRA for 101).
   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
      logic [3:0] code;
      case (f3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational D-stage decoder: opcode/funct3/funct7[5] to a control word,
// with disabled or unknown encodings producing an all-zero word plus illegal.
module ctrl_decoder
   import pipe_ctrl_pkg::*;
#(
   parameter bit EN_UPPER   = 1'b1,
   parameter bit EN_FULL_BR = 1'b1
) (
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output ctrl_t      ctrl
);

   logic br_ok;

   always_comb begin
      br_ok = (funct3[2:1] != 2'b01) && (EN_FULL_BR || (funct3[2:1] == 2'b00));
   end

   always_comb begin
      ctrl = '0;
      case (op)
         OP_R: begin
            ctrl.regwrite   = 1'b1;
            ctrl.alucontrol = alu_op(funct3, funct7_5);
         end
         OP_I: begin
            // Only the shift-right immediate form honours funct7[5] (SRAI).
            ctrl.regwrite   = 1'b1;
            ctrl.alusrc_b   = 1'b1;
            ctrl.immsrc     = IMM_I;
            ctrl.alucontrol = alu_op(funct3, funct7_5 && (funct3 == 3'b101));
         end
         OP_LOAD: begin
            ctrl.regwrite   = 1'b1;
            ctrl.alusrc_b   = 1'b1;
            ctrl.immsrc     = IMM_I;
            ctrl.resultsrc  = RES_MEM;
         end
         OP_STORE: begin
            ctrl.memwrite   = 1'b1;
            ctrl.alusrc_b   = 1'b1;
            ctrl.immsrc     = IMM_S;
         end
         OP_BRANCH: begin
            if (br_ok) begin
               ctrl.branch     = 1'b1;
               ctrl.immsrc     = IMM_B;
               ctrl.alucontrol = ALU_SUB;
            end else begin
               ctrl.illegal    = 1'b1;
            end
         end
         OP_JAL: begin
            ctrl.regwrite   = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.immsrc     = IMM_J;
            ctrl.resultsrc  = RES_PC4;
         end
         OP_JALR: begin
            ctrl.regwrite   = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.jalr       = 1'b1;
            ctrl.alusrc_b   = 1'b1;
            ctrl.immsrc     = IMM_I;
            ctrl.resultsrc  = RES_PC4;
         end
         OP_LUI: begin
            if (EN_UPPER) begin
               ctrl.regwrite   = 1'b1;
               ctrl.alusrc_a   = SRCA_ZERO;
               ctrl.alusrc_b   = 1'b1;
               ctrl.immsrc     = IMM_U;
            end else begin
               ctrl.illegal    = 1'b1;
            end
         end
         OP_AUIPC: begin
            if (EN_UPPER) begin
               ctrl.regwrite   = 1'b1;
               ctrl.alusrc_a   = SRCA_PC;
               ctrl.alusrc_b   = 1'b1;
               ctrl.immsrc     = IMM_U;
            end else begin
               ctrl.illegal    = 1'b1;
            end
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I pipeline control: decodes in D and carries controls through the
// ID/EX, EX/MEM and MEM/WB registers, resolving branches in E.
module pipelined_control_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned ALU_W      = 4,
   parameter bit          EN_UPPER   = 1'b1,
   parameter bit          EN_FULL_BR = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic             stall_e,
   input  logic             flush_e,
   input  logic             zero_e,
   input  logic             lt_e,
   input  logic             ltu_e,
   output logic [2:0]       immsrc_d,
   output logic             regwrite_e,
   output logic             memwrite_e,
   output logic             jump_e,
   output logic             branch_e,
   output logic [1:0]       alusrc_a_e,
   output logic             alusrc_b_e,
   output logic [ALU_W-1:0] alucontrol_e,
   output logic [1:0]       resultsrc_e,
   output logic             pcsrc_e,
   output logic             jalr_e,
   output logic             regwrite_m,
   output logic             memwrite_m,
   output logic [1:0]       resultsrc_m,
   output logic             regwrite_w,
   output logic [1:0]       resultsrc_w,
   output logic             illegal_w
);

   ctrl_t     dec_d;
   ex_ctrl_t  ex_d;
   ex_ctrl_t  ex_p0;
   mem_ctrl_t mem_p1;
   wb_ctrl_t  wb_p2;
   logic      cond_e;

   ctrl_decoder #(
      .EN_UPPER   (EN_UPPER),
      .EN_FULL_BR (EN_FULL_BR)
   ) u_dec (
      .op       (op),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .ctrl     (dec_d)
   );

   assign immsrc_d = dec_d.immsrc;

   always_comb begin
      ex_d            = '0;
      ex_d.regwrite   = dec_d.regwrite;
      ex_d.memwrite   = dec_d.memwrite;
      ex_d.jump       = dec_d.jump;
      ex_d.branch     = dec_d.branch;
      ex_d.jalr       = dec_d.jalr;
      ex_d.alusrc_a   = dec_d.alusrc_a;
      ex_d.alusrc_b   = dec_d.alusrc_b;
      ex_d.alucontrol = dec_d.alucontrol;
      ex_d.resultsrc  = dec_d.resultsrc;
      ex_d.illegal    = dec_d.illegal;
      ex_d.funct3     = funct3;
   end

   // D -> E boundary: flush outranks stall, both produce/keep a clean bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_p0 <= '0;
      end else if (flush_e) begin
         ex_p0 <= '0;
      end else if (!stall_e) begin
         ex_p0 <= ex_d;
      end
   end

   // E -> M boundary.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_p1 <= '0;
      end else begin
         mem_p1.regwrite  <= ex_p0.regwrite;
         mem_p1.memwrite  <= ex_p0.memwrite;
         mem_p1.resultsrc <= ex_p0.resultsrc;
         mem_p1.illegal   <= ex_p0.illegal;
      end
   end

   // M -> W boundary.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_p2 <= '0;
      end else begin
         wb_p2.regwrite  <= mem_p1.regwrite;
         wb_p2.resultsrc <= mem_p1.resultsrc;
         wb_p2.illegal   <= mem_p1.illegal;
      end
   end

   always_comb begin
      cond_e = 1'b0;
      case (ex_p0.funct3)
         F3_BEQ:  cond_e = zero_e;
         F3_BNE:  cond_e = !zero_e;
         F3_BLT:  cond_e = lt_e;
         F3_BGE:  cond_e = !lt_e;
         F3_BLTU: cond_e = ltu_e;
         F3_BGEU: cond_e = !ltu_e;
         default: cond_e = 1'b0;
      endcase
   end

   // Gated by rst_n so no redirect escapes before the first reset edge.
   assign pcsrc_e      = rst_n & (ex_p0.jump | (ex_p0.branch & cond_e));

   assign regwrite_e   = ex_p0.regwrite;
   assign memwrite_e   = ex_p0.memwrite;
   assign jump_e       = ex_p0.jump;
   assign branch_e     = ex_p0.branch;
   assign alusrc_a_e   = ex_p0.alusrc_a;
   assign alusrc_b_e   = ex_p0.alusrc_b;
   assign alucontrol_e = ALU_W'(ex_p0.alucontrol);
   assign resultsrc_e  = ex_p0.resultsrc;
   assign jalr_e       = ex_p0.jalr;

   assign regwrite_m   = mem_p1.regwrite;
   assign memwrite_m   = mem_p1.memwrite;
   assign resultsrc_m  = mem_p1.resultsrc;

   assign regwrite_w   = wb_p2.regwrite;
   assign resultsrc_w  = wb_p2.resultsrc;
   assign illegal_w    = wb_p2.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: full and reduced (no upper, BEQ/BNE only,
// 6-bit ALU code) instances driven in parallel against a behavioural model.
module tb_pipelined_control_unit;

   localparam logic [6:0] C_R   = 7'b0110011;
   localparam logic [6:0] C_I   = 7'b0010011;
   localparam logic [6:0] C_LD  = 7'b0000011;
   localparam logic [6:0] C_ST  = 7'b0100011;
   localparam logic [6:0] C_BR  = 7'b1100011;
   localparam logic [6:0] C_JAL = 7'b1101111;
   localparam logic [6:0] C_JR  = 7'b1100111;
   localparam logic [6:0] C_LUI = 7'b0110111;
   localparam logic [6:0] C_AUI = 7'b0010111;
   localparam logic [6:0] OPS [9] = '{C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JR, C_LUI, C_AUI};

   typedef struct packed {
      logic       rw, mw, jmp, br, jalr;
      logic [1:0] asrc;
      logic       bsrc;
      logic [3:0] alu;
      logic [1:0] res;
      logic [2:0] imm;
      logic       ill;
      logic [2:0] f3;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7_5 = 1'b0, stall_e = 1'b0, flush_e = 1'b0;
   logic       zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;

   logic [2:0] f_immsrc_d, r_immsrc_d;
   logic       f_regwrite_e, f_memwrite_e, f_jump_e, f_branch_e, f_alusrc_b_e, f_pcsrc_e, f_jalr_e;
   logic       r_regwrite_e, r_memwrite_e, r_jump_e, r_branch_e, r_alusrc_b_e, r_pcsrc_e, r_jalr_e;
   logic [1:0] f_alusrc_a_e, f_resultsrc_e, f_resultsrc_m, f_resultsrc_w;
   logic [1:0] r_alusrc_a_e, r_resultsrc_e, r_resultsrc_m, r_resultsrc_w;
   logic [3:0] f_alucontrol_e;
   logic [5:0] r_alucontrol_e;
   logic       f_regwrite_m, f_memwrite_m, f_regwrite_w, f_illegal_w;
   logic       r_regwrite_m, r_memwrite_m, r_regwrite_w, r_illegal_w;

   int   n_chk = 0;
   int   n_fail = 0;
   logic model_ok = 1'b0;
   exp_t st_e [2];
   exp_t st_m [2];
   exp_t st_w [2];

   always #5 clk = ~clk;

   pipelined_control_unit dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
      .stall_e(stall_e), .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .immsrc_d(f_immsrc_d), .regwrite_e(f_regwrite_e), .memwrite_e(f_memwrite_e),
      .jump_e(f_jump_e), .branch_e(f_branch_e), .alusrc_a_e(f_alusrc_a_e),
      .alusrc_b_e(f_alusrc_b_e), .alucontrol_e(f_alucontrol_e), .resultsrc_e(f_resultsrc_e),
      .pcsrc_e(f_pcsrc_e), .jalr_e(f_jalr_e), .regwrite_m(f_regwrite_m),
      .memwrite_m(f_memwrite_m), .resultsrc_m(f_resultsrc_m), .regwrite_w(f_regwrite_w),
      .resultsrc_w(f_resultsrc_w), .illegal_w(f_illegal_w)
   );

   pipelined_control_unit #(.ALU_W(6), .EN_UPPER(1'b0), .EN_FULL_BR(1'b0)) dut_r (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
      .stall_e(stall_e), .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .immsrc_d(r_immsrc_d), .regwrite_e(r_regwrite_e), .memwrite_e(r_memwrite_e),
      .jump_e(r_jump_e), .branch_e(r_branch_e), .alusrc_a_e(r_alusrc_a_e),
      .alusrc_b_e(r_alusrc_b_e), .alucontrol_e(r_alucontrol_e), .resultsrc_e(r_resultsrc_e),
      .pcsrc_e(r_pcsrc_e), .jalr_e(r_jalr_e), .regwrite_m(r_regwrite_m),
      .memwrite_m(r_memwrite_m), .resultsrc_m(r_resultsrc_m), .regwrite_w(r_regwrite_w),
      .resultsrc_w(r_resultsrc_w), .illegal_w(r_illegal_w)
   );

   function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
      case (f)
         3'd0:    return alt ? 4'b0001 : 4'b0000;
         3'd1:    return 4'b0111;
         3'd2:    return 4'b0101;
         3'd3:    return 4'b0110;
         3'd4:    return 4'b0100;
         3'd5:    return alt ? 4'b1001 : 4'b1000;
         3'd6:    return 4'b0011;
         default: return 4'b0010;
      endcase
   endfunction

   function automatic exp_t model_dec(input logic [6:0] o, input logic [2:0] f, input logic a,
                                      input bit up, input bit fullbr);
      exp_t c = '0;
      c.f3 = f;
      case (o)
         C_R:   begin c.rw = 1; c.alu = alu_of(f, a); end
         C_I:   begin c.rw = 1; c.bsrc = 1; c.alu = alu_of(f, a && f == 3'd5); end
         C_LD:  begin c.rw = 1; c.bsrc = 1; c.res = 2'b01; end
         C_ST:  begin c.mw = 1; c.bsrc = 1; c.imm = 3'b001; end
         C_BR:  begin
            if (f == 3'd2 || f == 3'd3 || (!fullbr && f > 3'd1)) c.ill = 1;
            else begin c.br = 1; c.imm = 3'b010; c.alu = 4'b0001; end
         end
         C_JAL: begin c.rw = 1; c.jmp = 1; c.res = 2'b10; c.imm = 3'b011; end
         C_JR:  begin c.rw = 1; c.jmp = 1; c.jalr = 1; c.bsrc = 1; c.res = 2'b10; end
         C_LUI: begin
            if (!up) c.ill = 1;
            else begin c.rw = 1; c.asrc = 2'b10; c.bsrc = 1; c.imm = 3'b100; end
         end
         C_AUI: begin
            if (!up) c.ill = 1;
            else begin c.rw = 1; c.asrc = 2'b01; c.bsrc = 1; c.imm = 3'b100; end
         end
         default: c.ill = 1;
      endcase
      return c;
   endfunction

   function automatic logic br_cond(input logic [2:0] f, input logic z, input logic l, input logic lu);
      logic base;
      case (f[2:1])
         2'b00:   base = z;
         2'b10:   base = l;
         2'b11:   base = lu;
         default: return 1'b0;
      endcase
      return base ^ f[0];
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            st_e[k] <= '0;
            st_m[k] <= '0;
            st_w[k] <= '0;
         end else begin
            st_w[k] <= st_m[k];
            st_m[k] <= st_e[k];
            if (flush_e) st_e[k] <= '0;
            else if (!stall_e) st_e[k] <= model_dec(op, funct3, funct7_5, k == 0, k == 0);
         end
      end
      model_ok <= 1'b1;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string t, input int k, input logic [2:0] imm_d,
                            input logic rw_e, input logic mw_e, input logic j_e, input logic b_e,
                            input logic [1:0] a_e, input logic bs_e, input logic [5:0] alu_e,
                            input logic [1:0] res_e, input logic pc_e, input logic jr_e,
                            input logic rw_m, input logic mw_m, input logic [1:0] res_m,
                            input logic rw_w, input logic [1:0] res_w, input logic ill_w);
      exp_t d, e, m, w;
      logic pc_x;
      d = model_dec(op, funct3, funct7_5, k == 0, k == 0);
      e = st_e[k];
      m = st_m[k];
      w = st_w[k];
      chk({t, "immsrc_d"}, 8'(imm_d), 8'(d.imm));
      if (!rst_n) chk({t, "pcsrc_rst"}, 8'(pc_e), 8'd0);
      if (model_ok) begin
         pc_x = rst_n & (e.jmp | (e.br & br_cond(e.f3, zero_e, lt_e, ltu_e)));
         chk({t, "regwrite_e"}, 8'(rw_e), 8'(e.rw));
         chk({t, "memwrite_e"}, 8'(mw_e), 8'(e.mw));
         chk({t, "jump_e"}, 8'(j_e), 8'(e.jmp));
         chk({t, "branch_e"}, 8'(b_e), 8'(e.br));
         chk({t, "alusrc_a_e"}, 8'(a_e), 8'(e.asrc));
         chk({t, "alusrc_b_e"}, 8'(bs_e), 8'(e.bsrc));
         chk({t, "alucontrol_e"}, 8'(alu_e), 8'(e.alu));
         chk({t, "resultsrc_e"}, 8'(res_e), 8'(e.res));
         chk({t, "pcsrc_e"}, 8'(pc_e), 8'(pc_x));
         chk({t, "jalr_e"}, 8'(jr_e), 8'(e.jalr));
         chk({t, "regwrite_m"}, 8'(rw_m), 8'(m.rw));
         chk({t, "memwrite_m"}, 8'(mw_m), 8'(m.mw));
         chk({t, "resultsrc_m"}, 8'(res_m), 8'(m.res));
         chk({t, "regwrite_w"}, 8'(rw_w), 8'(w.rw));
         chk({t, "resultsrc_w"}, 8'(res_w), 8'(w.res));
         chk({t, "illegal_w"}, 8'(ill_w), 8'(w.ill));
      end
   endtask

   task automatic compare_all();
      check_dut("full.", 0, f_immsrc_d, f_regwrite_e, f_memwrite_e, f_jump_e, f_branch_e,
                f_alusrc_a_e, f_alusrc_b_e, {2'b00, f_alucontrol_e}, f_resultsrc_e, f_pcsrc_e,
                f_jalr_e, f_regwrite_m, f_memwrite_m, f_resultsrc_m, f_regwrite_w,
                f_resultsrc_w, f_illegal_w);
      check_dut("red.", 1, r_immsrc_d, r_regwrite_e, r_memwrite_e, r_jump_e, r_branch_e,
                r_alusrc_a_e, r_alusrc_b_e, r_alucontrol_e, r_resultsrc_e, r_pcsrc_e,
                r_jalr_e, r_regwrite_m, r_memwrite_m, r_resultsrc_m, r_regwrite_w,
                r_resultsrc_w, r_illegal_w);
   endtask

   task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic a,
                        input logic st, input logic fl, input logic z, input logic l,
                        input logic lu, input logic rn);
      @(negedge clk);
      op = o; funct3 = f; funct7_5 = a; stall_e = st; flush_e = fl;
      zero_e = z; lt_e = l; ltu_e = lu; rst_n = rn;
      #1;
      compare_all();
   endtask

   task automatic d(input logic [6:0] o, input logic [2:0] f, input logic a);
      drive(o, f, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // Reset with a JAL presented: nothing may leak out.
      drive(C_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(C_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_regwrite_e", 8'(f_regwrite_e), 8'd0);
      chk("rst_jump_e", 8'(f_jump_e), 8'd0);
      chk("rst_pcsrc_e", 8'(f_pcsrc_e), 8'd0);
      chk("rst_regwrite_w", 8'(f_regwrite_w), 8'd0);
      chk("rst_illegal_w", 8'(f_illegal_w), 8'd0);

      // ADD then SUB.
      d(C_R, 3'd0, 1'b0);
      d(C_R, 3'd0, 1'b1);
      chk("add_alucontrol_e", 8'(f_alucontrol_e), 8'h0);
      chk("add_regwrite_e", 8'(f_regwrite_e), 8'd1);
      chk("add_alusrc_b_e", 8'(f_alusrc_b_e), 8'd0);
      d(C_I, 3'd0, 1'b0);
      chk("sub_alucontrol_e", 8'(f_alucontrol_e), 8'h1);
      d(C_I, 3'd0, 1'b0);
      chk("add_regwrite_w", 8'(f_regwrite_w), 8'd1);
      d(C_I, 3'd0, 1'b0);
      chk("sub_regwrite_w", 8'(f_regwrite_w), 8'd1);

      // LW then SW.
      d(C_LD, 3'd2, 1'b0);
      chk("lw_immsrc_d", 8'(f_immsrc_d), 8'd0);
      d(C_ST, 3'd2, 1'b0);
      chk("sw_immsrc_d", 8'(f_immsrc_d), 8'd1);
      chk("lw_resultsrc_e", 8'(f_resultsrc_e), 8'd1);
      d(C_I, 3'd0, 1'b0);
      chk("sw_memwrite_e", 8'(f_memwrite_e), 8'd1);
      chk("sw_regwrite_e", 8'(f_regwrite_e), 8'd0);
      d(C_I, 3'd0, 1'b0);
      chk("sw_memwrite_m", 8'(f_memwrite_m), 8'd1);

      // BLTU taken / not taken; illegal on the reduced instance.
      d(C_BR, 3'd6, 1'b0);
      drive(C_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("bltu_taken_pcsrc_e", 8'(f_pcsrc_e), 8'd1);
      chk("bltu_red_branch_e", 8'(r_branch_e), 8'd0);
      d(C_I, 3'd0, 1'b0);
      d(C_I, 3'd0, 1'b0);
      chk("bltu_red_illegal_w", 8'(r_illegal_w), 8'd1);
      chk("bltu_full_illegal_w", 8'(f_illegal_w), 8'd0);
      d(C_BR, 3'd6, 1'b0);
      drive(C_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("bltu_nt_pcsrc_e", 8'(f_pcsrc_e), 8'd0);

      // JAL flushed on its capture edge.
      drive(C_JAL, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      d(C_I, 3'd0, 1'b0);
      chk("jalflush_jump_e", 8'(f_jump_e), 8'd0);
      chk("jalflush_regwrite_e", 8'(f_regwrite_e), 8'd0);
      chk("jalflush_pcsrc_e", 8'(f_pcsrc_e), 8'd0);
      d(C_I, 3'd0, 1'b0);
      d(C_I, 3'd0, 1'b0);
      chk("jalflush_regwrite_w", 8'(f_regwrite_w), 8'd0);

      // LUI held by stall, then stall+flush yields a bubble.
      d(C_LUI, 3'd5, 1'b1);
      drive(C_I, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lui_alusrc_a_e", 8'(f_alusrc_a_e), 8'd2);
      chk("lui_alusrc_b_e", 8'(f_alusrc_b_e), 8'd1);
      chk("lui_alucontrol_e", 8'(f_alucontrol_e), 8'd0);
      chk("lui_red_regwrite_e", 8'(r_regwrite_e), 8'd0);
      drive(C_I, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lui_held_alusrc_a_e", 8'(f_alusrc_a_e), 8'd2);
      drive(C_I, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lui_held2_alusrc_a_e", 8'(f_alusrc_a_e), 8'd2);
      d(C_I, 3'd0, 1'b0);
      chk("stallflush_regwrite_e", 8'(f_regwrite_e), 8'd0);
      chk("stallflush_alusrc_a_e", 8'(f_alusrc_a_e), 8'd0);

      // Undefined opcode reaches W as illegal.
      d(7'h7f, 3'd0, 1'b0);
      d(C_I, 3'd0, 1'b0);
      chk("undef_regwrite_e", 8'(f_regwrite_e), 8'd0);
      d(C_I, 3'd0, 1'b0);
      d(C_I, 3'd0, 1'b0);
      chk("undef_illegal_w", 8'(f_illegal_w), 8'd1);
      chk("undef_regwrite_w", 8'(f_regwrite_w), 8'd0);

      // Same, but reset at cycle 2 discards it.
      d(7'h7f, 3'd0, 1'b0);
      d(C_I, 3'd0, 1'b0);
      drive(C_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      d(C_I, 3'd0, 1'b0);
      chk("midrst_illegal_w", 8'(f_illegal_w), 8'd0);
      chk("midrst_regwrite_e", 8'(f_regwrite_e), 8'd0);
      chk("midrst_regwrite_m", 8'(f_regwrite_m), 8'd0);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         logic [6:0] o;
         int sel;
         sel = $urandom_range(0, 11);
         o = (sel < 9) ? OPS[sel] : 7'($urandom);
         drive(o, 3'($urandom), 1'($urandom), ($urandom % 5) == 0, ($urandom % 8) == 0,
               1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 40) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
